// File: rtl/e203_icb_arbt_wrr.sv
// N-to-1 ICB command arbiter: weighted round-robin grant, lock-hold, in-order response-ID FIFO.
// Define ICB_ARBT_ZERO_CYCLE_RSP_EN to route a response that arrives with the command while the FIFO is empty.
module e203_icb_arbt_wrr #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int USR_W      = 1,
    parameter int ARBT_NUM   = 4,
    parameter int ARBT_PTR_W = 2,
    parameter int WEIGHT_W   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARBT_NUM*WEIGHT_W-1:0] arbt_weight,

    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_valid,
    output logic [ARBT_NUM-1:0]         i_bus_icb_cmd_ready,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_read,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_lock,
    input  logic [ARBT_NUM*AW-1:0]      i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*DW-1:0]      i_bus_icb_cmd_wdata,
    input  logic [ARBT_NUM*DW/8-1:0]    i_bus_icb_cmd_wmask,
    input  logic [ARBT_NUM*2-1:0]       i_bus_icb_cmd_size,
    input  logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_cmd_usr,

    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_valid,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_rsp_ready,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_err,
    output logic [ARBT_NUM*DW-1:0]      i_bus_icb_rsp_rdata,
    output logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_rsp_usr,

    output logic                        o_icb_cmd_valid,
    input  logic                        o_icb_cmd_ready,
    output logic                        o_icb_cmd_read,
    output logic [AW-1:0]               o_icb_cmd_addr,
    output logic [DW-1:0]               o_icb_cmd_wdata,
    output logic [DW/8-1:0]             o_icb_cmd_wmask,
    output logic [1:0]                  o_icb_cmd_size,
    output logic                        o_icb_cmd_lock,
    output logic [USR_W-1:0]            o_icb_cmd_usr,

    input  logic                        o_icb_rsp_valid,
    output logic                        o_icb_rsp_ready,
    input  logic                        o_icb_rsp_err,
    input  logic [DW-1:0]               o_icb_rsp_rdata,
    input  logic [USR_W-1:0]            o_icb_rsp_usr,

    output logic [CNT_W-1:0]            o_outs_cnt,
    output logic [ARBT_PTR_W-1:0]       arbt_cur_id
);

    localparam int MW   = DW / 8;
    localparam int HW   = WEIGHT_W + 1;
    localparam int FP_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ARBT_PTR_W-1:0] cur_ptr;
    logic [HW-1:0]         hold_cnt;
    logic                  locked;

    logic [ARBT_PTR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FP_W-1:0]       wr_ptr;
    logic [FP_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]      outs_cnt;

    logic [ARBT_NUM-1:0]   grant;
    logic [ARBT_PTR_W-1:0] grant_id;
    logic [ARBT_PTR_W:0]   scan_sum;
    logic [ARBT_PTR_W-1:0] scan_id;

    // Lowest offset from cur_ptr wins, so the loop runs from the farthest offset down.
    always_comb begin
        grant    = '0;
        grant_id = cur_ptr;
        scan_sum = '0;
        scan_id  = '0;
        if (locked) begin
            grant[cur_ptr] = i_bus_icb_cmd_valid[cur_ptr];
        end else begin
            for (int k = ARBT_NUM - 1; k >= 0; k--) begin
                scan_sum = {1'b0, cur_ptr} + (ARBT_PTR_W+1)'(k);
                if (scan_sum >= (ARBT_PTR_W+1)'(ARBT_NUM))
                    scan_sum = scan_sum - (ARBT_PTR_W+1)'(ARBT_NUM);
                scan_id = scan_sum[ARBT_PTR_W-1:0];
                if (i_bus_icb_cmd_valid[scan_id]) begin
                    grant          = '0;
                    grant[scan_id] = 1'b1;
                    grant_id       = scan_id;
                end
            end
        end
    end

    always_comb begin
        o_icb_cmd_read  = 1'b0;
        o_icb_cmd_lock  = 1'b0;
        o_icb_cmd_addr  = '0;
        o_icb_cmd_wdata = '0;
        o_icb_cmd_wmask = '0;
        o_icb_cmd_size  = '0;
        o_icb_cmd_usr   = '0;
        for (int i = 0; i < ARBT_NUM; i++) begin
            o_icb_cmd_read  = o_icb_cmd_read  | (grant[i] & i_bus_icb_cmd_read[i]);
            o_icb_cmd_lock  = o_icb_cmd_lock  | (grant[i] & i_bus_icb_cmd_lock[i]);
            o_icb_cmd_addr  = o_icb_cmd_addr  | ({AW{grant[i]}}    & i_bus_icb_cmd_addr[i*AW +: AW]);
            o_icb_cmd_wdata = o_icb_cmd_wdata | ({DW{grant[i]}}    & i_bus_icb_cmd_wdata[i*DW +: DW]);
            o_icb_cmd_wmask = o_icb_cmd_wmask | ({MW{grant[i]}}    & i_bus_icb_cmd_wmask[i*MW +: MW]);
            o_icb_cmd_size  = o_icb_cmd_size  | ({2{grant[i]}}     & i_bus_icb_cmd_size[i*2 +: 2]);
            o_icb_cmd_usr   = o_icb_cmd_usr   | ({USR_W{grant[i]}} & i_bus_icb_cmd_usr[i*USR_W +: USR_W]);
        end
    end

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ARBT_PTR_W-1:0] head_id;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  cmd_room;
    logic                  cmd_hsk;
    logic                  byp_hsk;
    logic [ARBT_PTR_W-1:0] rsp_id;
    logic                  rsp_en;

    assign fifo_empty = (outs_cnt == '0);
    assign fifo_full  = (outs_cnt == CNT_W'(FIFO_DEPTH));
    assign head_id    = fifo_mem[rd_ptr];

    // A pop in the same cycle frees the slot for a command when full.
    assign fifo_pop = o_icb_rsp_valid & ~fifo_empty & i_bus_icb_rsp_ready[head_id];
    assign cmd_room = ~fifo_full | fifo_pop;

    assign o_icb_cmd_valid     = (|grant) & cmd_room;
    assign i_bus_icb_cmd_ready = grant & {ARBT_NUM{o_icb_cmd_ready & cmd_room}};
    assign cmd_hsk             = o_icb_cmd_valid & o_icb_cmd_ready;

`ifdef ICB_ARBT_ZERO_CYCLE_RSP_EN
    assign rsp_id  = fifo_empty ? grant_id : head_id;
    assign rsp_en  = fifo_empty ? cmd_hsk : 1'b1;
    assign byp_hsk = fifo_empty & cmd_hsk & o_icb_rsp_valid & i_bus_icb_rsp_ready[grant_id];
`else
    assign rsp_id  = head_id;
    assign rsp_en  = ~fifo_empty;
    assign byp_hsk = 1'b0;
`endif

    assign fifo_push = cmd_hsk & ~byp_hsk;

    always_comb begin
        i_bus_icb_rsp_valid         = '0;
        i_bus_icb_rsp_valid[rsp_id] = o_icb_rsp_valid & rsp_en;
    end

    assign o_icb_rsp_ready     = rsp_en & i_bus_icb_rsp_ready[rsp_id];
    assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};
    assign i_bus_icb_rsp_usr   = {ARBT_NUM{o_icb_rsp_usr}};

    logic [WEIGHT_W-1:0]   grant_weight;
    logic [HW-1:0]         hold_next;
    logic [ARBT_PTR_W-1:0] next_id;

    assign grant_weight = arbt_weight[grant_id*WEIGHT_W +: WEIGHT_W];
    assign hold_next    = (grant_id == cur_ptr) ? (hold_cnt + HW'(1)) : HW'(1);
    assign next_id      = (grant_id == ARBT_PTR_W'(ARBT_NUM - 1)) ? '0 : (grant_id + ARBT_PTR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ptr  <= '0;
            hold_cnt <= '0;
            locked   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            outs_cnt <= '0;
        end else begin
            if (cmd_hsk) begin
                if (o_icb_cmd_lock) begin
                    locked  <= 1'b1;
                    cur_ptr <= grant_id;
                end else begin
                    locked <= 1'b0;
                    if (hold_next > {1'b0, grant_weight}) begin
                        cur_ptr  <= next_id;
                        hold_cnt <= '0;
                    end else begin
                        cur_ptr  <= grant_id;
                        hold_cnt <= hold_next;
                    end
                end
            end
            if (fifo_push)
                wr_ptr <= (wr_ptr == FP_W'(FIFO_DEPTH - 1)) ? '0 : (wr_ptr + FP_W'(1));
            if (fifo_pop)
                rd_ptr <= (rd_ptr == FP_W'(FIFO_DEPTH - 1)) ? '0 : (rd_ptr + FP_W'(1));
            if (fifo_push & ~fifo_pop)
                outs_cnt <= outs_cnt + CNT_W'(1);
            else if (fifo_pop & ~fifo_push)
                outs_cnt <= outs_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= grant_id;
    end

    assign o_outs_cnt  = outs_cnt;
    assign arbt_cur_id = cur_ptr;

endmodule
